// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one combinational WIDTH-bit ALU between two requesters. A round-robin
// arbiter picks one valid request per cycle, drives its operands and selects
// onto the ALU, and captures the ALU result and carry into a one-entry response
// register tagged with the requester id.
//
// Optional feature (compile-time macro ALU_ARB_STATS_EN):
//   defined   - cnt0/cnt1 count grants to requester 0/1, saturating at
//               2^CNT_W-1, cleared by rst.
//   undefined - no counter registers; cnt0/cnt1 are tied to zero.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   req0_valid/ready    requester 0 handshake (ready is combinational from valid)
//   req0_op             {s0,s1,s2}: add, sub, inc A, dec A, and, or, xor, sra A
//   req0_a, req0_b      requester 0 operands
//   req1_*              same five signals for requester 1
//   alu_a, alu_b        operands to the shared ALU (zero when nothing granted)
//   alu_s0/s1/s2        ALU selects (000 when nothing granted)
//   alu_out, alu_carr   ALU result and carry, valid in the same cycle
//   rsp_valid/ready     response handshake
//   rsp_id              requester that owns the held response
//   rsp_out, rsp_carry  registered result and carry (carry is 0 for op[2]=1)
//   cnt0, cnt1          grant counters
// -----------------------------------------------------------------------------
`ifndef NUM_BITS
`define NUM_BITS 4
`endif

module alu_rr_arbiter #(
  parameter int WIDTH = `NUM_BITS,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic             alu_s2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;   // id of the most recent grantee; 1 after reset so req0 wins first
  logic   can_accept;
  logic   grant0;
  logic   grant1;

  // ---------------------------------------------------------------------------
  // Arbitration, ALU drive and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt  = state;
    can_accept = (state == EMPTY) || rsp_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    {alu_s0, alu_s1, alu_s2} = 3'b000;

    // Reset dominates: no grant is issued during a reset cycle.
    if (!rst && can_accept) begin
      // On contention the requester that did not win last time goes next.
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end

    req0_ready = grant0;
    req1_ready = grant1;

    if (grant0) begin
      alu_a = req0_a;
      alu_b = req0_b;
      {alu_s0, alu_s1, alu_s2} = req0_op;
    end else if (grant1) begin
      alu_a = req1_a;
      alu_b = req1_b;
      {alu_s0, alu_s1, alu_s2} = req1_op;
    end

    // A grant refills the slot in the same cycle the old response drains,
    // giving one operation per cycle.
    if (grant0 || grant1) begin
      state_nxt = FULL;
    end else if (state == FULL && rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  assign rsp_valid = (state == FULL);

  // ---------------------------------------------------------------------------
  // Response register and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the response payload is reset as well as the valid flag, so the
    // outputs show defined values (not X) before the first grant.
    if (rst) begin
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      rsp_out    <= alu_out;
      // alu_s0 carries op[2]; the ALU carry is undefined for logic/shift ops.
      rsp_carry  <= alu_carr & ~alu_s0;
      rsp_id     <= grant1;
      last_grant <= grant1;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant0 && (cnt0 != {CNT_W{1'b1}})) cnt0 <= cnt0 + CNT_W'(1);
      if (grant1 && (cnt1 != {CNT_W{1'b1}})) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//
// Drives alu_rr_arbiter with a behavioural ALU attached to its ALU port and
// compares every observable output against a reference model of the sharing
// rules (who is granted, what the response holds, grant statistics).
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

  localparam int W     = 4;
  localparam int CW    = 8;
  localparam int CMAX  = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [2:0]    req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic          alu_s0, alu_s1, alu_s2, alu_carr;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [W-1:0]  rsp_out;
  logic [CW-1:0] cnt0, cnt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_out(alu_out), .alu_carr(alu_carr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // Attached ALU. Carry is driven high for logic/shift ops so the arbiter's
  // masking of that undefined carry is observable.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case ({alu_s0, alu_s1, alu_s2})
      3'b000:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'b010:  alu_sum = {1'b0, alu_a} + 5'd1;
      3'b011:  alu_sum = {1'b0, alu_a} + 5'b01111;
      3'b100:  alu_sum = {1'b1, alu_a & alu_b};
      3'b101:  alu_sum = {1'b1, alu_a | alu_b};
      3'b110:  alu_sum = {1'b1, alu_a ^ alu_b};
      default: alu_sum = {1'b1, alu_a[W-1], alu_a[W-1:1]};
    endcase
  end
  assign alu_out  = alu_sum[W-1:0];
  assign alu_carr = alu_sum[W];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit          m_full, m_carry, m_id, m_last;
  logic [3:0]  m_out;
  int          m_cnt0, m_cnt1;
  bit          e_g0, e_g1;

  // Expected {carry, result} from the operation definitions in plain integers.
  function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r;
    bit c;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 15);  end
      3'd1: begin r = ai - bi; c = (ai >= bi); end
      3'd2: begin r = ai + 1;  c = (r > 15);  end
      3'd3: begin r = ai - 1;  c = (ai > 0);  end
      3'd4: begin r = int'(a & b); c = 1'b0; end
      3'd5: begin r = int'(a | b); c = 1'b0; end
      3'd6: begin r = int'(a ^ b); c = 1'b0; end
      default: begin r = ai / 2 + ((ai >= 8) ? 8 : 0); c = 1'b0; end
    endcase
    return {c, r[3:0]};
  endfunction

  task automatic calc_grant();
    bit acc;
    acc  = !rst && (!m_full || rsp_ready);
    e_g0 = acc && req0_valid && (!req1_valid || m_last);
    e_g1 = acc && req1_valid && (!req0_valid || !m_last);
  endtask

  // Advance one clock and update the model with what should have happened.
  task automatic tick();
    logic [2:0] op;
    logic [3:0] a, b;
    calc_grant();
    op = e_g1 ? req1_op : req0_op;
    a  = e_g1 ? req1_a  : req0_a;
    b  = e_g1 ? req1_b  : req0_b;
    @(posedge clk);
    #1;
    if (rst) begin
      m_full = 0; m_carry = 0; m_id = 0; m_out = '0; m_last = 1;
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (e_g0 || e_g1) begin
      {m_carry, m_out} = ref_alu(op, a, b);
      m_full = 1;
      m_id   = e_g1;
      m_last = e_g1;
`ifdef ALU_ARB_STATS_EN
      if (e_g0 && m_cnt0 < CMAX) m_cnt0++;
      if (e_g1 && m_cnt1 < CMAX) m_cnt1++;
`endif
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
  endtask

  task automatic set_idle();
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    rst = 1; set_idle(); tick(); rst = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1; rsp_ready = 1; set_idle();
    req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    else passed++;
    tick(); tick();
    rst = 0; set_idle(); #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== 7'b0)
      $display("FAIL reset_rsp: got %b expected 0000000", {rsp_valid, rsp_id, rsp_carry, rsp_out});
    else passed++;
    total++;
    if ({cnt0, cnt1} !== '0)
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1);
    else passed++;
  endtask

  task automatic test_add_latency();
    rsp_ready = 1;
    req0_valid = 1; req0_op = 3'b000; req0_a = 4'b1001; req0_b = 4'b0101;
    #1;
    total++;
    if ({req0_ready, req1_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2} !== {2'b10, 4'b1001, 4'b0101, 3'b000})
      $display("FAIL add_grant: got rdy=%b a=%b b=%b s=%b expected rdy=10 a=1001 b=0101 s=000",
               {req0_ready, req1_ready}, alu_a, alu_b, {alu_s0, alu_s1, alu_s2});
    else passed++;
    tick(); set_idle();
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== {1'b1, 1'b0, 1'b0, 4'b1110})
      $display("FAIL add_rsp: got v=%b id=%b c=%b out=%b expected v=1 id=0 c=0 out=1110",
               rsp_valid, rsp_id, rsp_carry, rsp_out);
    else passed++;
    #1;
    total++;
    if ({alu_a, alu_b, alu_s0, alu_s1, alu_s2} !== '0)
      $display("FAIL idle_alu_drive: got a=%b b=%b expected zeros", alu_a, alu_b);
    else passed++;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req0_op = 3'($urandom_range(0, 7));
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_valid = 1; req1_op = 3'($urandom_range(0, 7));
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      #1;
      total++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_ready[%0d]: got %b", i, {req0_ready, req1_ready});
      else passed++;
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== {1'b1, 1'(i % 2), m_carry, m_out})
        $display("FAIL rr_rsp[%0d]: got v=%b id=%b c=%b out=%b expected v=1 id=%0d c=%b out=%b",
                 i, rsp_valid, rsp_id, rsp_carry, rsp_out, i % 2, m_carry, m_out);
      else passed++;
    end
    set_idle(); tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1; set_idle(); tick();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'b001; req0_a = 4'b1001; req0_b = 4'b0101;
    #1;
    total++;
    if (req0_ready !== 1'b1) $display("FAIL bp_first_grant: got %b expected 1", req0_ready);
    else passed++;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_op = 3'b000; req1_a = 4'b0011; req1_b = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b00)
        $display("FAIL bp_stall_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
      else passed++;
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== {1'b1, 1'b0, 1'b1, 4'b0100})
        $display("FAIL bp_hold[%0d]: got v=%b id=%b c=%b out=%b expected v=1 id=0 c=1 out=0100",
                 i, rsp_valid, rsp_id, rsp_carry, rsp_out);
      else passed++;
    end
    rsp_ready = 1;
    #1;
    total++;
    if (req1_ready !== 1'b1) $display("FAIL bp_release_grant: got %b expected 1", req1_ready);
    else passed++;
    tick(); set_idle();
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== {1'b1, 1'b1, 1'b0, 4'b0111})
      $display("FAIL bp_release_rsp: got v=%b id=%b c=%b out=%b expected v=1 id=1 c=0 out=0111",
               rsp_valid, rsp_id, rsp_carry, rsp_out);
    else passed++;
    tick();
  endtask

  task automatic test_ops();
    logic [2:0] ops [3] = '{3'b010, 3'b110, 3'b111};
    logic [3:0] as  [3] = '{4'b1111, 4'b1001, 4'b1001};
    logic [3:0] bs  [3] = '{4'b0110, 4'b0101, 4'b0011};
    logic [4:0] exp [3] = '{5'b1_0000, 5'b0_1100, 5'b0_1100};
    rsp_ready = 1; set_idle();
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1; req1_op = ops[i]; req1_a = as[i]; req1_b = bs[i];
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== {2'b11, exp[i]})
        $display("FAIL op_%0d: got v=%b id=%b c=%b out=%b expected v=1 id=1 c/out=%b",
                 i, rsp_valid, rsp_id, rsp_carry, rsp_out, exp[i]);
      else passed++;
    end
    set_idle(); tick();
  endtask

  // Leaves req0 as the last grantee, so only the reset can make req0 win next.
  task automatic test_reset_midop();
    rsp_ready = 1; set_idle();
    req0_valid = 1; req0_op = 3'b000; req0_a = 4'd2; req0_b = 4'd3;
    tick();
    set_idle(); rsp_ready = 0; tick();
    rst = 1; rsp_ready = 1; req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("FAIL midrst_ready: got %b expected 00", {req0_ready, req1_ready});
    else passed++;
    tick();
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL midrst_drop: got %b expected 0", rsp_valid);
    else passed++;
    rst = 0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL midrst_first_grant: got %b expected 10", {req0_ready, req1_ready});
    else passed++;
    tick(); set_idle(); tick();
  endtask

  task automatic test_random();
    bit p0, p1;
    p0 = 0; p1 = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // A request that was valid but not accepted must be held unchanged.
      if (!p0) begin
        req0_valid = ($urandom_range(0, 99) < 60); req0_op = 3'($urandom_range(0, 7));
        req0_a = 4'($urandom); req0_b = 4'($urandom);
      end
      if (!p1) begin
        req1_valid = ($urandom_range(0, 99) < 60); req1_op = 3'($urandom_range(0, 7));
        req1_a = 4'($urandom); req1_b = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 99) < 2);
      #1;
      calc_grant();
      total++;
      if ({req0_ready, req1_ready} !== {e_g0, e_g1})
        $display("FAIL rand_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, {e_g0, e_g1});
      else passed++;
      total++;
      if ({alu_a, alu_b, alu_s0, alu_s1, alu_s2} !==
          (e_g0 ? {req0_a, req0_b, req0_op} : e_g1 ? {req1_a, req1_b, req1_op} : 11'b0))
        $display("FAIL rand_alu_drive[%0d]: got a=%b b=%b s=%b", i, alu_a, alu_b, {alu_s0, alu_s1, alu_s2});
      else passed++;
      p0 = req0_valid && !e_g0;
      p1 = req1_valid && !e_g1;
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_out} !== {m_full, m_id, m_carry, m_out})
        $display("FAIL rand_rsp[%0d]: got v=%b id=%b c=%b out=%b expected v=%b id=%b c=%b out=%b",
                 i, rsp_valid, rsp_id, rsp_carry, rsp_out, m_full, m_id, m_carry, m_out);
      else passed++;
      total++;
      if ({cnt0, cnt1} !== {CW'(m_cnt0), CW'(m_cnt1)})
        $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, m_cnt0, m_cnt1);
      else passed++;
    end
    rst = 0; set_idle(); rsp_ready = 1; tick();
  endtask

  task automatic test_stats();
    int exp0;
`ifdef ALU_ARB_STATS_EN
    exp0 = CMAX;
`else
    exp0 = 0;
`endif
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 300; i++) begin
      req0_valid = 1; req0_op = 3'($urandom_range(0, 7));
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      tick();
    end
    set_idle();
    total++;
    if ({cnt0, cnt1} !== {CW'(exp0), CW'(0)})
      $display("FAIL stats_saturate: got %0d/%0d expected %0d/0", cnt0, cnt1, exp0);
    else passed++;
    tick();
  endtask

  initial begin
    rst = 1; rsp_ready = 1; set_idle();
    m_full = 0; m_carry = 0; m_id = 0; m_out = '0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    test_reset();
    test_add_latency();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_reset_midop();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
